// File: rtl/col_sched_if.sv
// -----------------------------------------------------------------------------
// col_sched_if
// Column-scheduler bus: the slot strobe and its payload, the column-fetch
// valid/ready request, and the status outputs.
//   slave  modport : scheduler side (col_sched)
//   master modport : driver side (slot source, frame manager, status reader)
// Signals:
//   theta_valid_in  - one-cycle strobe, new angular slot
//   dtheta_in       - slot angle, sampled with the strobe
//   col_mask_in     - columns to consider, sampled with the strobe
//   col_valid_out   - column request valid
//   col_idx_out     - requested column index
//   col_dtheta_out  - slot angle attached to the request
//   col_ready_in    - downstream accepts the request
//   busy_out        - slot in progress
//   frame_done_out  - one-cycle slot completion pulse
//   overrun_out     - one-cycle pulse when a strobe is dropped
//   overrun_cnt_out - saturating count of dropped strobes
// -----------------------------------------------------------------------------
interface col_sched_if #(
   parameter int ROTATIONAL_RES = 256,
   parameter int NUM_COLS       = 64,
   parameter int OVR_CNT_W      = 16
) ();
   localparam int DTH_W = $clog2(ROTATIONAL_RES);
   localparam int IDX_W = $clog2(NUM_COLS);

   logic                 theta_valid_in;
   logic [DTH_W-1:0]     dtheta_in;
   logic [NUM_COLS-1:0]  col_mask_in;
   logic                 col_valid_out;
   logic [IDX_W-1:0]     col_idx_out;
   logic [DTH_W-1:0]     col_dtheta_out;
   logic                 col_ready_in;
   logic                 busy_out;
   logic                 frame_done_out;
   logic                 overrun_out;
   logic [OVR_CNT_W-1:0] overrun_cnt_out;

   modport slave (
      input  theta_valid_in, dtheta_in, col_mask_in, col_ready_in,
      output col_valid_out, col_idx_out, col_dtheta_out,
             busy_out, frame_done_out, overrun_out, overrun_cnt_out
   );

   modport master (
      output theta_valid_in, dtheta_in, col_mask_in, col_ready_in,
      input  col_valid_out, col_idx_out, col_dtheta_out,
             busy_out, frame_done_out, overrun_out, overrun_cnt_out
   );
endinterface

// File: rtl/col_sched.sv
// -----------------------------------------------------------------------------
// col_sched
// Per-angular-slot column scheduler for the rotating display. A slot strobe
// captures the slot angle and the column mask; the mask is then walked from
// column 0 upward, issuing one valid/ready request per enabled column and
// spending one cycle per masked-off column. Completion, busy status and
// dropped strobes (overruns) are reported.
// Ports:
//   clk_in - system clock
//   rst_in - synchronous, active-high reset
//   bus    - col_sched_if.slave (strobe/payload, column request, status)
// Optional feature (macro COL_SCHED_PENDING_EN): a one-deep pending slot
//   register absorbs a strobe arriving mid-slot; only a strobe that finds the
//   pending register already full counts as an overrun (newest slot wins).
// -----------------------------------------------------------------------------
module col_sched #(
   parameter int ROTATIONAL_RES = 256,
   parameter int NUM_COLS       = 64,
   parameter int OVR_CNT_W      = 16
) (
   input logic        clk_in,
   input logic        rst_in,
   col_sched_if.slave bus
);
   localparam int DTH_W = $clog2(ROTATIONAL_RES);
   localparam int IDX_W = $clog2(NUM_COLS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state;
   logic [IDX_W-1:0]     idx;
   logic [IDX_W-1:0]     idx_nxt;
   logic [NUM_COLS-1:0]  mask_q;
   logic [DTH_W-1:0]     dtheta_q;
   logic                 col_valid_r;
   logic                 busy_r;
   logic                 frame_done_r;
   logic                 overrun_r;
   logic [OVR_CNT_W-1:0] overrun_cnt;
   logic                 advance;

`ifdef COL_SCHED_PENDING_EN
   logic                 pend_full;
   logic [NUM_COLS-1:0]  pend_mask;
   logic [DTH_W-1:0]     pend_dtheta;
`endif

   function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
      return (&v) ? v : v + OVR_CNT_W'(1);
   endfunction

   assign idx_nxt = idx + IDX_W'(1);

   // col_valid_r mirrors mask_q[idx] while running, so a masked-off column
   // (valid low) always advances and an enabled one advances only on ready.
   assign advance = !col_valid_r || bus.col_ready_in;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state        <= IDLE;
         idx          <= '0;
         mask_q       <= '0;
         dtheta_q     <= '0;
         col_valid_r  <= 1'b0;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
         overrun_r    <= 1'b0;
         overrun_cnt  <= '0;
`ifdef COL_SCHED_PENDING_EN
         pend_full    <= 1'b0;
         pend_mask    <= '0;
         pend_dtheta  <= '0;
`endif
      end else begin
         frame_done_r <= 1'b0;
         overrun_r    <= 1'b0;
         case (state)
            RUN: begin
               if (bus.theta_valid_in) begin
`ifdef COL_SCHED_PENDING_EN
                  pend_full   <= 1'b1;
                  pend_mask   <= bus.col_mask_in;
                  pend_dtheta <= bus.dtheta_in;
                  if (pend_full) begin
                     overrun_r   <= 1'b1;
                     overrun_cnt <= sat_inc(overrun_cnt);
                  end
`else
                  overrun_r   <= 1'b1;
                  overrun_cnt <= sat_inc(overrun_cnt);
`endif
               end
               if (advance) begin
                  if (idx == LAST_IDX) begin
                     // Index and angle are zeroed so the request outputs
                     // read 0 whenever no slot is running.
                     state        <= DONE;
                     idx          <= '0;
                     dtheta_q     <= '0;
                     col_valid_r  <= 1'b0;
                     busy_r       <= 1'b0;
                     frame_done_r <= 1'b1;
                  end else begin
                     idx         <= idx_nxt;
                     col_valid_r <= mask_q[idx_nxt];
                  end
               end
            end
            default: begin
               // IDLE and DONE both accept a new slot, so a strobe in the
               // done cycle starts the next slot without an idle bubble.
`ifdef COL_SCHED_PENDING_EN
               if (state == DONE && pend_full) begin
                  state       <= RUN;
                  idx         <= '0;
                  mask_q      <= pend_mask;
                  dtheta_q    <= pend_dtheta;
                  col_valid_r <= pend_mask[0];
                  busy_r      <= 1'b1;
                  pend_full   <= bus.theta_valid_in;
                  if (bus.theta_valid_in) begin
                     pend_mask   <= bus.col_mask_in;
                     pend_dtheta <= bus.dtheta_in;
                  end
               end else
`endif
               if (bus.theta_valid_in) begin
                  state       <= RUN;
                  idx         <= '0;
                  mask_q      <= bus.col_mask_in;
                  dtheta_q    <= bus.dtheta_in;
                  col_valid_r <= bus.col_mask_in[0];
                  busy_r      <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   assign bus.col_valid_out   = col_valid_r;
   assign bus.col_idx_out     = idx;
   assign bus.col_dtheta_out  = dtheta_q;
   assign bus.busy_out        = busy_r;
   assign bus.frame_done_out  = frame_done_r;
   assign bus.overrun_out     = overrun_r;
   assign bus.overrun_cnt_out = overrun_cnt;
endmodule

// File: tb/tb_col_sched.sv
// -----------------------------------------------------------------------------
// tb_col_sched
// Bench for col_sched (64 columns, 256 slots, 16-bit overrun counter) plus a
// small instance (4 columns, 3-bit counter) used to reach counter saturation.
// Directed slots cover the scheduling scenarios; a randomized phase compares
// every cycle against a slot-level reference model. Honours
// COL_SCHED_PENDING_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_col_sched;
   logic clk = 1'b0;
   logic rst_in;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   hs_q[$];
   int   sat_pulses = 0;

   always #5 clk = ~clk;

   col_sched_if #(.ROTATIONAL_RES(256), .NUM_COLS(64), .OVR_CNT_W(16)) bus ();
   col_sched_if #(.ROTATIONAL_RES(16),  .NUM_COLS(4),  .OVR_CNT_W(3))  sb ();

   col_sched #(.ROTATIONAL_RES(256), .NUM_COLS(64), .OVR_CNT_W(16)) dut (
      .clk_in(clk), .rst_in(rst_in), .bus(bus)
   );

   col_sched #(.ROTATIONAL_RES(16), .NUM_COLS(4), .OVR_CNT_W(3)) dut_small (
      .clk_in(clk), .rst_in(rst_in), .bus(sb)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- reference model (slot level) ----------------
   bit          m_act = 0;
   int          m_pos = 0;
   logic [63:0] m_mask = '0;
   logic [7:0]  m_dth = '0;
   bit          m_done = 0;
   bit          m_ovr = 0;
   int          m_cnt = 0;
   bit          p_full = 0;
   logic [63:0] p_mask = '0;
   logic [7:0]  p_dth = '0;

   task automatic begin_slot(input logic [63:0] mk, input logic [7:0] d);
      m_act = 1; m_pos = 0; m_mask = mk; m_dth = d;
   endtask

   task automatic count_drop();
      m_ovr = 1;
      if (m_cnt < 65535) m_cnt++;
   endtask

   task automatic model_edge(input bit r, input bit tv, input logic [7:0] d,
                             input logic [63:0] mk, input bit rdy);
      bit was_done;
      was_done = m_done;
      m_done = 0; m_ovr = 0;
      if (r) begin
         m_act = 0; m_pos = 0; m_cnt = 0; p_full = 0;
         return;
      end
      if (m_act) begin
         if (tv) begin
`ifdef COL_SCHED_PENDING_EN
            if (p_full) count_drop();
            p_full = 1; p_mask = mk; p_dth = d;
`else
            count_drop();
`endif
         end
         // a column is finished when it is masked off or its request is taken
         if (!m_mask[m_pos] || rdy) begin
            if (m_pos == 63) begin
               m_act = 0; m_done = 1;
            end else begin
               m_pos++;
            end
         end
      end else begin
`ifdef COL_SCHED_PENDING_EN
         if (was_done && p_full) begin
            begin_slot(p_mask, p_dth);
            p_full = tv;
            if (tv) begin p_mask = mk; p_dth = d; end
         end else if (tv) begin_slot(mk, d);
`else
         if (tv) begin_slot(mk, d);
`endif
      end
   endtask

   function automatic logic [63:0] dut_vec(input bit raw);
      logic [5:0] i;
      logic [7:0] t;
      i = (raw || m_act) ? bus.col_idx_out : 6'd0;
      t = (raw || m_act) ? bus.col_dtheta_out : 8'd0;
      return 64'({bus.col_valid_out, i, t, bus.busy_out, bus.frame_done_out,
                  bus.overrun_out, bus.overrun_cnt_out});
   endfunction

   function automatic logic [63:0] exp_vec();
      logic       v;
      logic [5:0] i;
      logic [7:0] t;
      v = m_act && m_mask[m_pos];
      i = m_act ? 6'(m_pos) : 6'd0;
      t = m_act ? m_dth : 8'd0;
      return 64'({v, i, t, 1'(m_act), 1'(m_done), 1'(m_ovr), 16'(m_cnt)});
   endfunction

   // one clock: drive inputs, let the edge happen, then compare outputs
   task automatic step(input bit r, input bit tv, input logic [7:0] d,
                       input logic [63:0] mk, input bit rdy);
      bit hs;
      int hs_idx;
      rst_in = r;
      bus.theta_valid_in = tv;
      bus.dtheta_in = d;
      bus.col_mask_in = mk;
      bus.col_ready_in = rdy;
      hs = bus.col_valid_out && rdy;
      hs_idx = int'(bus.col_idx_out);
      @(posedge clk);
      cyc++;
      model_edge(r, tv, d, mk, rdy);
      #1;
      chk("cycle", dut_vec(1'b0), exp_vec());
      if (hs && !r) hs_q.push_back(hs_idx);
   endtask

   // Strobe a slot, then run with ready high (optionally stalling at one
   // column and injecting one extra strobe) until the done pulse.
   task automatic run_slot(input logic [7:0] d, input logic [63:0] mk,
                           input int stall_idx, input int stall_n,
                           input int extra_at, input logic [7:0] extra_d,
                           output int delta, output int held, output int ovr_at);
      int t0;
      int s;
      bit rdy;
      hs_q.delete();
      held = 0; s = stall_n; delta = -1; ovr_at = -1;
      step(1'b0, 1'b1, d, mk, 1'b1);
      t0 = cyc;
      for (int k = 1; k <= 200; k++) begin
         rdy = 1'b1;
         if (bus.col_valid_out && int'(bus.col_idx_out) == stall_idx) begin
            held++;
            if (s > 0) begin rdy = 1'b0; s--; end
         end
         step(1'b0, k == extra_at, extra_d, '1, rdy);
         if (bus.overrun_out && ovr_at < 0) ovr_at = cyc - t0;
         if (bus.frame_done_out) begin
            delta = cyc - t0;
            break;
         end
      end
   endtask

   always @(negedge clk)
      if (!rst_in && sb.overrun_out && sb.overrun_cnt_out == 3'd7) sat_pulses++;

   initial begin
      int  delta, held, ovr_at;
      bit  ok;
      bit  tv, r, rdy;
      logic [63:0] mk;
      logic [63:0] m3;

      rst_in = 1'b1;
      bus.theta_valid_in = 1'b0; bus.dtheta_in = '0; bus.col_mask_in = '0; bus.col_ready_in = 1'b0;
      sb.theta_valid_in = 1'b1; sb.dtheta_in = 4'h3; sb.col_mask_in = 4'hF; sb.col_ready_in = 1'b1;

      // reset, with a strobe in the same cycle that must lose to reset
      step(1'b1, 1'b0, 8'h00, '0, 1'b0);
      step(1'b1, 1'b1, 8'h55, '1, 1'b1);
      chk("reset_state", dut_vec(1'b1), 64'd0);

      // full mask, dtheta 0x2A: 64 requests in order, done 64 edges after strobe
      run_slot(8'h2A, '1, -1, 0, 0, 8'h00, delta, held, ovr_at);
      chk("full_done_lat", 64'(delta), 64'd64);
      chk("full_hs_cnt", 64'(hs_q.size()), 64'd64);
      ok = 1;
      foreach (hs_q[i]) if (hs_q[i] != i) ok = 0;
      chk("full_hs_order", 64'(ok), 64'd1);
      chk("full_busy_at_done", 64'(bus.busy_out), 64'd0);

      // sparse mask: bits 0, 5, 63
      m3 = '0; m3[0] = 1'b1; m3[5] = 1'b1; m3[63] = 1'b1;
      run_slot(8'h07, m3, -1, 0, 0, 8'h00, delta, held, ovr_at);
      chk("sparse_done_lat", 64'(delta), 64'd64);
      chk("sparse_hs_cnt", 64'(hs_q.size()), 64'd3);
      if (hs_q.size() == 3) chk("sparse_hs_idx", 64'({hs_q[0], hs_q[1], hs_q[2]}), 64'({32'd0, 32'd5}) << 32 | 64'd63);

      // empty mask: no requests, same completion time
      run_slot(8'h09, '0, -1, 0, 0, 8'h00, delta, held, ovr_at);
      chk("empty_done_lat", 64'(delta), 64'd64);
      chk("empty_hs_cnt", 64'(hs_q.size()), 64'd0);

      // backpressure: ready low 3 cycles at column 7
      run_slot(8'h3C, '1, 7, 3, 0, 8'h00, delta, held, ovr_at);
      chk("stall_done_lat", 64'(delta), 64'd67);
      chk("stall_hold", 64'(held), 64'd4);
      chk("stall_hs_cnt", 64'(hs_q.size()), 64'd64);

      // second strobe 10 cycles into a slot
      step(1'b1, 1'b0, 8'h00, '0, 1'b0);
      run_slot(8'h20, '1, -1, 0, 10, 8'h11, delta, held, ovr_at);
      chk("ovr_done_lat", 64'(delta), 64'd64);
      chk("ovr_hs_cnt", 64'(hs_q.size()), 64'd64);
`ifdef COL_SCHED_PENDING_EN
      chk("pend_no_ovr", 64'(ovr_at), 64'hFFFF_FFFF_FFFF_FFFF);
      chk("pend_cnt0", 64'(bus.overrun_cnt_out), 64'd0);
      step(1'b0, 1'b0, 8'h00, '0, 1'b1);
      chk("pend_next_slot", 64'({bus.col_valid_out, bus.col_idx_out, bus.col_dtheta_out}),
          64'({1'b1, 6'd0, 8'h11}));
      step(1'b0, 1'b0, 8'h00, '0, 1'b1);
      step(1'b0, 1'b1, 8'h12, '1, 1'b1);
      chk("pend_fill_no_ovr", 64'(bus.overrun_out), 64'd0);
      step(1'b0, 1'b0, 8'h00, '0, 1'b1);
      step(1'b0, 1'b1, 8'h13, '1, 1'b1);
      chk("pend_full_ovr", 64'({bus.overrun_out, bus.overrun_cnt_out}), 64'({1'b1, 16'd1}));
`else
      chk("ovr_pulse_at", 64'(ovr_at), 64'd10);
      chk("ovr_cnt", 64'(bus.overrun_cnt_out), 64'd1);
`endif

      // reset mid-slot at column 20, strobe right after reset releases
      step(1'b1, 1'b0, 8'h00, '0, 1'b0);
      step(1'b0, 1'b1, 8'h33, '1, 1'b1);
      for (int k = 0; k < 100; k++) begin
         if (bus.col_idx_out == 6'd20) break;
         step(1'b0, 1'b0, 8'h00, '0, 1'b1);
      end
      chk("mid_at_idx20", 64'(bus.col_idx_out), 64'd20);
      step(1'b1, 1'b0, 8'h00, '0, 1'b1);
      chk("mid_reset_outs", dut_vec(1'b1), 64'd0);
      run_slot(8'h44, '1, -1, 0, 0, 8'h00, delta, held, ovr_at);
      chk("post_rst_done_lat", 64'(delta), 64'd64);
      chk("post_rst_first_idx", 64'(hs_q.size() > 0 ? hs_q[0] : -1), 64'd0);

      // randomized traffic against the model
      mk = '1;
      for (int k = 0; k < 3000; k++) begin
         r   = ($urandom % 700) == 0;
         tv  = m_act ? (($urandom % 50) == 0) : (($urandom % 4) == 0);
         rdy = ($urandom % 10) < 7;
         case ($urandom % 4)
            0:       mk = '0;
            1:       mk = '1;
            default: mk = {$urandom, $urandom};
         endcase
         step(r, tv, 8'($urandom), mk, rdy);
      end

      for (int k = 0; k < 40; k++) step(1'b0, 1'b0, 8'h00, '0, 1'b1);
      chk("small_sat_cnt", 64'(sb.overrun_cnt_out), 64'd7);
      chk("small_sat_pulses", 64'(sat_pulses > 0), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/col_sched.md
Name: col_sched

Overview:
- Per-angular-slot column scheduler for the rotating display.
- On each new angular slot (dtheta strobe), captures dtheta and the column-consider mask, then walks the mask from column 0 upward.
- Issues one valid/ready request per enabled column to the frame manager's column-fetch path.
- Reports slot completion, busy status, and slot overruns (strobe arriving before the previous slot finished).

Parameters:
- ROTATIONAL_RES, 256, angular slots per revolution; dtheta width = $clog2(ROTATIONAL_RES).
- NUM_COLS, 64, number of columns (power of 2); index width = $clog2(NUM_COLS).
- OVR_CNT_W, 16, width of saturating overrun counter.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- theta_valid_in  input  1  one-cycle strobe: new angular slot begins
- dtheta_in  input  $clog2(ROTATIONAL_RES)  slot angle, sampled with theta_valid_in
- col_mask_in  input  NUM_COLS  columns to consider, sampled with theta_valid_in
- col_valid_out  output  1  column request valid
- col_idx_out  output  $clog2(NUM_COLS)  requested column index
- col_dtheta_out  output  $clog2(ROTATIONAL_RES)  latched dtheta for the request
- col_ready_in  input  1  downstream accepts request
- busy_out  output  1  high while a slot is in progress
- frame_done_out  output  1  one-cycle pulse at slot completion
- overrun_out  output  1  one-cycle pulse when a strobe is dropped
- overrun_cnt_out  output  OVR_CNT_W  saturating count of dropped strobes

Behaviour:
- Reset (rst_in high at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0; idx, mask_q, dtheta_q and overrun_cnt are cleared.
  - Reset mid-slot abandons the slot with no done pulse.
  - Reset dominates theta_valid_in in the same cycle.
- States: IDLE, RUN, DONE.
- IDLE:
  - theta_valid_in at cycle T latches mask_q, dtheta_q, sets idx=0, goes to RUN.
  - RUN is visible at T+1.
- RUN:
  - col_valid_out = mask_q[idx], col_idx_out = idx, col_dtheta_out = dtheta_q. All outputs are driven from registers only.
  - Advance condition: mask_q[idx]==0 (skip, one cycle per masked-off column), or col_valid_out && col_ready_in (handshake).
  - On advance: if idx==NUM_COLS-1, go to DONE; else idx+1.
  - Without an advance condition, all outputs hold stable. Valid must not drop and index must not change under backpressure.
- DONE: frame_done_out=1 for exactly one cycle, then IDLE.
- Also accept in DONE: a theta_valid_in arriving in DONE is accepted as in IDLE, going directly to RUN with no idle bubble.
- busy_out = 1 in RUN, 0 in IDLE and DONE.
- Latency:
  - Strobe at T with mask bit 0 set gives the first valid at T+1.
  - Full mask with ready held high gives valid on T+1..T+NUM_COLS and done at T+NUM_COLS+1.
  - Empty mask gives no valid; done at T+NUM_COLS+1.
- Overrun (theta_valid_in while in RUN):
  - The strobe is dropped.
  - overrun_out pulses the next cycle.
  - overrun_cnt increments, saturating at all-ones.
  - The current slot continues unaffected.
- Width rules:
  - idx never wraps past NUM_COLS-1.
  - dtheta is passed through unmodified; no arithmetic on it.

Optional Feature:
- Macro: COL_SCHED_PENDING_EN.
- Defined:
  - A one-deep pending slot register holds mask and dtheta.
  - A strobe during RUN fills pending if it is empty; no overrun.
  - A strobe while pending is already full overwrites pending, pulses overrun_out and increments the counter (newest slot wins).
  - On entering DONE with pending full: frame_done_out pulses, pending loads into mask_q/dtheta_q with idx=0, and the next state is RUN. Pending clears.
  - A simultaneous strobe in that DONE cycle refills pending.
  - Reset clears pending.
- Undefined: every strobe in RUN is dropped as described above.

Test Plan:
- Reset, full mask all-ones, dtheta=0x2A, ready high, strobe at T -> col_valid_out high T+1..T+64 with col_idx_out 0..63 and col_dtheta_out=0x2A; frame_done_out at T+65; busy_out low at T+65.
- Mask with only bits 0, 5 and 63 set -> exactly three handshakes, indices 0, 5, 63 in order; done at T+65.
- Full mask, ready low for 3 cycles at idx=7 -> valid and idx=7 held stable for 4 cycles; total completion delayed by 3 cycles.
- Second strobe at T+10 during RUN (feature off) -> overrun_out pulses at T+11; overrun_cnt_out=1; first slot completes unchanged.
  - 65536 further overruns -> counter saturates at 0xFFFF.
- rst_in asserted mid-slot at idx=20 -> next cycle all outputs 0, state IDLE, no done pulse.
  - A strobe the cycle after reset deasserts starts cleanly at idx 0.
- COL_SCHED_PENDING_EN: strobe during RUN with dtheta=0x11 -> no overrun; after done pulse, new slot begins the same cycle with col_dtheta_out=0x11 at idx 0.
  - A third strobe while pending is full -> overrun=1.
